// File: rtl/dmem_responder.sv
// dmem_responder: shared data-memory responder for the multi-core CCSS build.
// Arbitrates among NUM_CORES requesting cores, performs one single-port RAM
// access at a time and returns read data with a one-cycle acknowledge.
// Optional feature macro: DMEM_RR_ARB_EN (round-robin arbitration when
// defined, fixed lowest-index priority when undefined).
module dmem_responder #(
  parameter int NUM_CORES = 4,
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 16,
  parameter int DEPTH     = 256
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_CORES-1:0]        req,
  input  logic [NUM_CORES-1:0]        we,
  input  logic [NUM_CORES*ADDR_W-1:0] addr,
  input  logic [NUM_CORES*DATA_W-1:0] wdata,
  output logic [NUM_CORES-1:0]        ack,
  output logic [DATA_W-1:0]           rdata,
  output logic                        busy
);

  localparam int CW    = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       grant_q, grant_d;
  logic                gwe_q, gwe_d;
  logic [IDX_W-1:0]    gaddr_q, gaddr_d;
  logic [DATA_W-1:0]   gwdata_q, gwdata_d;
  logic [DATA_W-1:0]   rdata_q;
  logic [CW-1:0]       pick;
  logic                anyReq;
  logic                unusedAddr;

  logic [DATA_W-1:0]   mem [DEPTH];

`ifdef DMEM_RR_ARB_EN
  logic [CW-1:0]       rr_q, rr_d;
`endif

  // Address bits above the RAM index are deliberately ignored (aliasing).
  assign unusedAddr = ^addr;

  // Arbiter: choose which requesting core would be granted this cycle.
  always_comb begin
    pick   = '0;
    anyReq = |req;
`ifdef DMEM_RR_ARB_EN
    begin
      int            idx;
      logic          found;
      logic [CW-1:0] cand;
      idx   = 0;
      found = 1'b0;
      cand  = '0;
      for (int k = 0; k < NUM_CORES; k++) begin
        idx = int'(rr_q) + k;
        if (idx >= NUM_CORES) idx = idx - NUM_CORES;
        cand = CW'(idx);
        if (!found && req[cand]) begin
          pick  = cand;
          found = 1'b1;
        end
      end
    end
`else
    for (int k = NUM_CORES - 1; k >= 0; k--) begin
      if (req[k]) pick = CW'(k);
    end
`endif
  end

  // Next-state logic: latch the winner in IDLE, access RAM, then acknowledge.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    gwe_d    = gwe_q;
    gaddr_d  = gaddr_q;
    gwdata_d = gwdata_q;
`ifdef DMEM_RR_ARB_EN
    rr_d     = rr_q;
`endif
    case (state_q)
      IDLE: begin
        if (anyReq) begin
          grant_d  = pick;
          gwe_d    = we[pick];
          gaddr_d  = addr[int'(pick)*ADDR_W +: IDX_W];
          gwdata_d = wdata[int'(pick)*DATA_W +: DATA_W];
`ifdef DMEM_RR_ARB_EN
          rr_d     = (pick == CW'(NUM_CORES - 1)) ? '0 : pick + 1'b1;
`endif
          state_d  = ACCESS;
        end
      end
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode from registered state only.
  always_comb begin
    ack   = (state_q == RESP) ? (NUM_CORES'(1) << grant_q) : '0;
    busy  = (state_q != IDLE);
    rdata = rdata_q;
  end

  // State, grant registers and read-data register with asynchronous reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      gwe_q    <= 1'b0;
      gaddr_q  <= '0;
      gwdata_q <= '0;
      rdata_q  <= '0;
`ifdef DMEM_RR_ARB_EN
      rr_q     <= '0;
`endif
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      gwe_q    <= gwe_d;
      gaddr_q  <= gaddr_d;
      gwdata_q <= gwdata_d;
`ifdef DMEM_RR_ARB_EN
      rr_q     <= rr_d;
`endif
      if (state_q == ACCESS && !gwe_q) rdata_q <= mem[gaddr_q];
    end
  end

  // RAM write port; contents are never reset, and a reset during ACCESS
  // forces IDLE before the write edge so the write is dropped.
  always_ff @(posedge clk) begin
    if (state_q == ACCESS && gwe_q) mem[gaddr_q] <= gwdata_q;
  end

endmodule
